// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins; a one-entry hold buffer parks long-latency results.
// Latency: pipeline write appears on rf_* one edge later; a parked result drains at the first edge with no pipeline write.
// Backpressure: lu_ready drops while the buffer is full and cannot drain; stall_req asks for WB bubbles after STARVE_LIMIT blocked edges.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   wb_we/wb_waddr/wb_wdata       pipeline writeback (MEM/WB register)
//   lu_valid/lu_ready/lu_waddr/lu_wdata  long-latency unit result handshake
//   flush                         discard the held result
//   rf_we/rf_waddr/rf_wdata       registered register-file write port
//   stall_req                     registered request for pipeline bubbles
//   pend_valid/pend_waddr         hold-buffer occupancy for hazard detection
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  input  logic              flush,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_waddr
);

  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  // Bit 0 is the hold-buffer valid flag, bit 1 the stall request, so both
  // outputs come straight from state flops.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    STARVE = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0] hold_waddr;
  logic [DATA_W-1:0] hold_wdata;

  logic              hold_valid;
  logic              pipe_w;
  logic              squash;
  logic              drain_now;
  logic              load;
  logic              blocked;
  logic              rf_we_nxt;
  logic [ADDR_W-1:0] rf_waddr_nxt;
  logic [DATA_W-1:0] rf_wdata_nxt;

  assign hold_valid = state[0];
  // Writes to r0 are architecturally dead, so they never occupy the port.
  assign pipe_w     = wb_we & (wb_waddr != '0);
  // A younger pipeline write to the same register makes the held value stale.
  assign squash     = pipe_w & hold_valid & (wb_waddr == hold_waddr);
  assign drain_now  = hold_valid & ~pipe_w & ~flush;
  assign blocked    = hold_valid & pipe_w & ~squash;
  // lu_ready already excludes the squash/blocked cases, so a load can only
  // coincide with an empty buffer or a drain of the old entry.
  assign load       = lu_valid & lu_ready & (lu_waddr != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    if (flush) begin
      state_nxt    = IDLE;
      wait_cnt_nxt = '0;
    end else if (load) begin
      state_nxt    = HOLD;
      wait_cnt_nxt = '0;
    end else if (drain_now || squash) begin
      state_nxt    = IDLE;
      wait_cnt_nxt = '0;
    end else if (blocked && (state == HOLD)) begin
      if (wait_cnt == CNT_LAST) begin
        state_nxt = STARVE;
      end else begin
        wait_cnt_nxt = wait_cnt + CNT_W'(1);
      end
    end
  end

  // Output logic
  always_comb begin
    lu_ready     = ~rst & ~flush & (~hold_valid | drain_now);
    rf_we_nxt    = pipe_w | drain_now;
    rf_waddr_nxt = pipe_w ? wb_waddr : hold_waddr;
    rf_wdata_nxt = pipe_w ? wb_wdata : hold_wdata;
  end

  // Datapath: hold buffer and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_waddr <= '0;
      hold_wdata <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      if (load) begin
        hold_waddr <= lu_waddr;
        hold_wdata <= lu_wdata;
      end
      rf_we <= rf_we_nxt;
      // Address/data keep their last value on idle cycles.
      if (rf_we_nxt) begin
        rf_waddr <= rf_waddr_nxt;
        rf_wdata <= rf_wdata_nxt;
      end
    end
  end

  assign stall_req  = state[1];
  assign pend_valid = hold_valid;
  assign pend_waddr = hold_waddr;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic        pend_valid;
  logic [4:0]  pend_waddr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .pend_valid(pend_valid), .pend_waddr(pend_waddr)
  );

  // Inputs for one cycle, lu_ready expected before the edge, outputs expected after it.
  typedef struct {
    logic        we;  logic [4:0] wa; logic [31:0] wd;
    logic        lv;  logic [4:0] la; logic [31:0] ld;
    logic        fl;
    logic        rdy;
    logic        rwe; logic [4:0] rwa; logic [31:0] rwd;
    logic        st;  logic pv; logic [4:0] pa;
    int          id;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic lv, input logic [4:0] la, input logic [31:0] ld, input logic fl,
    input logic rdy, input logic rwe, input logic [4:0] rwa, input logic [31:0] rwd,
    input logic st, input logic pv, input logic [4:0] pa);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.lv = lv; v.la = la; v.ld = ld; v.fl = fl;
    v.rdy = rdy; v.rwe = rwe; v.rwa = rwa; v.rwd = rwd; v.st = st; v.pv = pv; v.pa = pa;
    v.id = 0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    lu_valid = 0; lu_waddr = 0; lu_wdata = 0; flush = 0;
  endtask

  // Drive a vector mid-cycle, check lu_ready, queue the post-edge expectation,
  // then pop and compare just after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    wb_we = v.we; wb_waddr = v.wa; wb_wdata = v.wd;
    lu_valid = v.lv; lu_waddr = v.la; lu_wdata = v.ld; flush = v.fl;
    #1;
    chk($sformatf("v%0d lu_ready", v.id), {31'd0, lu_ready}, {31'd0, v.rdy});
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d rf_we", e.id), {31'd0, rf_we}, {31'd0, e.rwe});
    if (e.rwe) begin
      chk($sformatf("v%0d rf_waddr", e.id), {27'd0, rf_waddr}, {27'd0, e.rwa});
      chk($sformatf("v%0d rf_wdata", e.id), rf_wdata, e.rwd);
    end
    chk($sformatf("v%0d stall_req", e.id), {31'd0, stall_req}, {31'd0, e.st});
    chk($sformatf("v%0d pend_valid", e.id), {31'd0, pend_valid}, {31'd0, e.pv});
    if (e.pv)
      chk($sformatf("v%0d pend_waddr", e.id), {27'd0, pend_waddr}, {27'd0, e.pa});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rf_we"}, {31'd0, rf_we}, 32'd0);
    chk({tag, " rf_waddr"}, {27'd0, rf_waddr}, 32'd0);
    chk({tag, " rf_wdata"}, rf_wdata, 32'd0);
    chk({tag, " stall_req"}, {31'd0, stall_req}, 32'd0);
    chk({tag, " pend_valid"}, {31'd0, pend_valid}, 32'd0);
    chk({tag, " pend_waddr"}, {27'd0, pend_waddr}, 32'd0);
    chk({tag, " lu_ready"}, {31'd0, lu_ready}, 32'd0);
  endtask

  initial begin
    //                 we wa  wd          lv la  ld            fl  rdy rwe rwa rwd           st pv pa
    // idle after reset
    tbl.push_back(mk(0, 0, 0,          0, 0,  0,            0,  1,  0,  0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,  0,            0,  1,  0,  0, 0,            0, 0, 0));
    // lu r7 accepted, drains next edge
    tbl.push_back(mk(0, 0, 0,          1, 7,  32'hDEADBEEF, 0,  1,  0,  0, 0,            0, 1, 7));
    tbl.push_back(mk(0, 0, 0,          0, 0,  0,            0,  1,  1,  7, 32'hDEADBEEF, 0, 0, 0));
    // r9 blocked by 5 pipeline writes, stall after the 4th
    tbl.push_back(mk(0, 0, 0,          1, 9,  32'h99,       0,  1,  0,  0, 0,            0, 1, 9));
    tbl.push_back(mk(1, 2, 32'h2,      0, 0,  0,            0,  0,  1,  2, 32'h2,        0, 1, 9));
    tbl.push_back(mk(1, 3, 32'h3,      0, 0,  0,            0,  0,  1,  3, 32'h3,        0, 1, 9));
    tbl.push_back(mk(1, 4, 32'h4,      0, 0,  0,            0,  0,  1,  4, 32'h4,        0, 1, 9));
    tbl.push_back(mk(1, 5, 32'h5,      0, 0,  0,            0,  0,  1,  5, 32'h5,        1, 1, 9));
    tbl.push_back(mk(1, 6, 32'h6,      0, 0,  0,            0,  0,  1,  6, 32'h6,        1, 1, 9));
    tbl.push_back(mk(0, 0, 0,          0, 0,  0,            0,  1,  1,  9, 32'h99,       0, 0, 0));
    // WAW squash: younger pipeline r3 write wins, stale r3 never written
    tbl.push_back(mk(0, 0, 0,          1, 3,  32'h55,       0,  1,  0,  0, 0,            0, 1, 3));
    tbl.push_back(mk(1, 3, 32'h11,     0, 0,  0,            0,  0,  1,  3, 32'h11,       0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,  0,            0,  1,  0,  0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,  0,            0,  1,  0,  0, 0,            0, 0, 0));
    // r0 result consumed and dropped; pipeline r0 write does not block r4
    tbl.push_back(mk(0, 0, 0,          1, 0,  32'hAB,       0,  1,  0,  0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,  0,            0,  1,  0,  0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          1, 4,  32'h44,       0,  1,  0,  0, 0,            0, 1, 4));
    tbl.push_back(mk(1, 0, 32'hEE,     0, 0,  0,            0,  1,  1,  4, 32'h44,       0, 0, 0));
    // back-to-back results via drain+load
    tbl.push_back(mk(0, 0, 0,          1, 10, 32'hA0,       0,  1,  0,  0, 0,            0, 1, 10));
    tbl.push_back(mk(0, 0, 0,          1, 11, 32'hB0,       0,  1,  1, 10, 32'hA0,       0, 1, 11));
    tbl.push_back(mk(0, 0, 0,          1, 12, 32'hC0,       0,  1,  1, 11, 32'hB0,       0, 1, 12));
    tbl.push_back(mk(0, 0, 0,          0, 0,  0,            0,  1,  1, 12, 32'hC0,       0, 0, 0));
    // flush while starving; pipeline write still lands
    tbl.push_back(mk(0, 0, 0,          1, 8,  32'h88,       0,  1,  0,  0, 0,            0, 1, 8));
    tbl.push_back(mk(1, 2, 32'h12,     0, 0,  0,            0,  0,  1,  2, 32'h12,       0, 1, 8));
    tbl.push_back(mk(1, 3, 32'h13,     0, 0,  0,            0,  0,  1,  3, 32'h13,       0, 1, 8));
    tbl.push_back(mk(1, 4, 32'h14,     0, 0,  0,            0,  0,  1,  4, 32'h14,       0, 1, 8));
    tbl.push_back(mk(1, 6, 32'h16,     0, 0,  0,            0,  0,  1,  6, 32'h16,       1, 1, 8));
    tbl.push_back(mk(1, 5, 32'h77,     0, 0,  0,            1,  0,  1,  5, 32'h77,       0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          1, 13, 32'hD0,       1,  0,  0,  0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,  0,            0,  1,  0,  0, 0,            0, 0, 0));

    // Reset: outputs zero and lu_ready low even with a result offered.
    drive_idle();
    rst = 1'b1;
    lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h1234;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_hold");
    drive_idle();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      v.id = i;
      step(v);
    end

    // Asynchronous reset mid-hold: outputs clear before any clock edge,
    // and the parked result never reaches the port.
    begin
      vec_t v;
      v = mk(0, 0, 0, 1, 14, 32'hE4, 0, 1, 0, 0, 0, 0, 1, 14);
      v.id = 100;
      step(v);
      @(negedge clk);
      drive_idle();
      #1 rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      v.id = 101;
      step(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
